// File: rtl/spi_display_receiver_if.sv
// rtl/spi_display_receiver_if.sv - SPI display link (MOSI/DC/CS) between drawing engine and receiver
interface spi_display_receiver_if;
    logic mosi;
    logic dc;
    logic cs;

    modport master (output mosi, output dc, output cs);
    modport slave  (input mosi, input dc, input cs);
endinterface

// File: rtl/spi_display_receiver.sv
// rtl/spi_display_receiver.sv - SPI display receiver: byte assembly, 2A/2B/2C decode, pixel strobes
module spi_display_receiver #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    spi_display_receiver_if.slave  spi,
    output logic                   o_cmd_valid,
    output logic [7:0]             o_cmd,
    output logic                   o_pix_valid,
    output logic [8:0]             o_pix_x,
    output logic [8:0]             o_pix_y,
    output logic [15:0]            o_pix_color,
    output logic                   o_err
);
    localparam logic [9:0] X_LIM = 10'(WIDTH);
    localparam logic [9:0] Y_LIM = 10'(HEIGHT);
    localparam logic [8:0] X_MAX = 9'(WIDTH - 1);
    localparam logic [8:0] Y_MAX = 9'(HEIGHT - 1);

    typedef enum logic [2:0] {ST_CMD, ST_CASET, ST_PASET, ST_RAMWR, ST_IGNORE} state_t;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift;
    logic [1:0]  param_idx;
    logic [8:0]  param_start;
    logic        end_hi;
    logic        pix_half;
    logic [7:0]  hi_byte;
    logic [8:0]  xs, xe, ys, ye;
    logic [8:0]  cur_x, cur_y;

    // The byte completes on the edge that samples its 8th bit; dc is taken on that same edge.
    logic        byte_done;
    logic [7:0]  rx_byte;
    logic [8:0]  param_end;
    logic        start_gt_end;
    assign byte_done    = !spi.cs && (bit_cnt == 3'd7);
    assign rx_byte      = {shift, spi.mosi};
    assign param_end    = {end_hi, rx_byte};
    assign start_gt_end = param_start > param_end;

    // Shift MOSI in while selected; deselect throws away any partial byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt <= 3'd0;
            shift   <= 7'd0;
        end else if (spi.cs) begin
            bit_cnt <= 3'd0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= rx_byte[6:0];
        end
    end

    // Decode completed bytes into window updates and cursor-tagged pixel strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_CMD;
            param_idx   <= 2'd0;
            param_start <= 9'd0;
            end_hi      <= 1'b0;
            pix_half    <= 1'b0;
            hi_byte     <= 8'd0;
            xs          <= 9'd0;
            xe          <= X_MAX;
            ys          <= 9'd0;
            ye          <= Y_MAX;
            cur_x       <= 9'd0;
            cur_y       <= 9'd0;
            o_cmd_valid <= 1'b0;
            o_cmd       <= 8'd0;
            o_pix_valid <= 1'b0;
            o_pix_x     <= 9'd0;
            o_pix_y     <= 9'd0;
            o_pix_color <= 16'd0;
            o_err       <= 1'b0;
        end else begin
            o_cmd_valid <= 1'b0;
            o_pix_valid <= 1'b0;
            if (byte_done) begin
                if (!spi.dc) begin
                    o_cmd_valid <= 1'b1;
                    o_cmd       <= rx_byte;
                    param_idx   <= 2'd0;
                    pix_half    <= 1'b0;
                    case (rx_byte)
                        8'h2A:   state <= ST_CASET;
                        8'h2B:   state <= ST_PASET;
                        8'h2C: begin
                            state <= ST_RAMWR;
                            cur_x <= xs;
                            cur_y <= ys;
                        end
                        default: state <= ST_IGNORE;
                    endcase
                end else begin
                    case (state)
                        ST_CASET, ST_PASET: begin
                            param_idx <= param_idx + 2'd1;
                            case (param_idx)
                                2'd0: param_start[8]   <= rx_byte[0];
                                2'd1: param_start[7:0] <= rx_byte;
                                2'd2: end_hi           <= rx_byte[0];
                                default: begin
                                    // The window is taken even when it is flagged bad.
                                    state <= ST_CMD;
                                    if (state == ST_CASET) begin
                                        xs <= param_start;
                                        xe <= param_end;
                                        if (start_gt_end || ({1'b0, param_end} >= X_LIM))
                                            o_err <= 1'b1;
                                    end else begin
                                        ys <= param_start;
                                        ye <= param_end;
                                        if (start_gt_end || ({1'b0, param_end} >= Y_LIM))
                                            o_err <= 1'b1;
                                    end
                                end
                            endcase
                        end
                        ST_RAMWR: begin
                            pix_half <= !pix_half;
                            if (!pix_half) begin
                                hi_byte <= rx_byte;
                            end else begin
                                o_pix_valid <= 1'b1;
                                o_pix_x     <= cur_x;
                                o_pix_y     <= cur_y;
                                o_pix_color <= {hi_byte, rx_byte};
                                if (cur_x == xe) begin
                                    cur_x <= xs;
                                    cur_y <= (cur_y == ye) ? ys : cur_y + 9'd1;
                                end else begin
                                    cur_x <= cur_x + 9'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_display_receiver.sv
// tb/tb_spi_display_receiver.sv - scoreboard bench for spi_display_receiver
module tb_spi_display_receiver;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_color;
    logic        err;

    spi_display_receiver_if spi_bus ();

    spi_display_receiver #(.WIDTH(240), .HEIGHT(320)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .spi         (spi_bus.slave),
        .o_cmd_valid (cmd_valid),
        .o_cmd       (cmd),
        .o_pix_valid (pix_valid),
        .o_pix_x     (pix_x),
        .o_pix_y     (pix_y),
        .o_pix_color (pix_color),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] c;
    } pix_t;

    pix_t       exp_pix[$];
    logic [7:0] exp_cmd[$];
    int         pix_cyc[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_cmd = 0;
    int         n_pix = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard whenever the DUT strobes.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (cmd_valid === 1'b1 || pix_valid === 1'b1)) begin
            checks++;
            assert ((cmd_valid & pix_valid) === 1'b0) else begin
                errors++;
                $error("FAIL strobe_overlap observed=%b%b expected=one strobe", cmd_valid, pix_valid);
            end
            if (cmd_valid === 1'b1) begin
                n_cmd++;
                checks++;
                assert (exp_cmd.size() != 0) else begin
                    errors++;
                    $error("FAIL cmd_unexpected observed=%h expected=none", cmd);
                end
                if (exp_cmd.size() != 0) begin
                    logic [7:0] e;
                    e = exp_cmd.pop_front();
                    checks++;
                    assert (cmd === e) else begin
                        errors++;
                        $error("FAIL cmd observed=%h expected=%h", cmd, e);
                    end
                end
            end
            if (pix_valid === 1'b1) begin
                n_pix++;
                pix_cyc.push_back(cyc);
                checks++;
                assert (exp_pix.size() != 0) else begin
                    errors++;
                    $error("FAIL pix_unexpected observed=(%0d,%0d)=%h expected=none", pix_x, pix_y, pix_color);
                end
                if (exp_pix.size() != 0) begin
                    pix_t p;
                    p = exp_pix.pop_front();
                    checks++;
                    assert ({pix_x, pix_y, pix_color} === {p.x, p.y, p.c}) else begin
                        errors++;
                        $error("FAIL pix observed=(%0d,%0d)=%h expected=(%0d,%0d)=%h",
                               pix_x, pix_y, pix_color, p.x, p.y, p.c);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            spi_bus.cs   = 1'b0;
            spi_bus.mosi = b[i];
            spi_bus.dc   = d;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        exp_cmd.push_back(b);
        send_byte(b, 1'b0);
    endtask

    task automatic send_pix(input logic [15:0] c, input logic [8:0] x, input logic [8:0] y);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        exp_pix.push_back(p);
        send_byte(c[15:8], 1'b1);
        send_byte(c[7:0], 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            spi_bus.cs = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        idle(4);
        check({tag, "_cmd_pending"}, 64'(exp_cmd.size()), 64'd0);
        check({tag, "_pix_pending"}, 64'(exp_pix.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({cmd_valid, cmd, pix_valid, pix_x, pix_y, pix_color, err});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        // Reset with random line activity
        rst_n = 1'b0;
        spi_bus.cs = 1'b1;
        spi_bus.mosi = 1'b0;
        spi_bus.dc = 1'b0;
        repeat (6) begin
            @(negedge clk);
            spi_bus.cs   = 1'($urandom);
            spi_bus.mosi = 1'($urandom);
            spi_bus.dc   = 1'($urandom);
            #1 check("reset_outputs", all_outputs(), 64'd0);
        end
        @(negedge clk);
        spi_bus.cs = 1'b1;
        rst_n = 1'b1;
        n0 = n_cmd + n_pix;
        send_byte(8'hAA, 1'b1);
        idle(3);
        check("data_after_reset_no_strobe", 64'(n_cmd + n_pix), 64'(n0));

        // Unknown command, then default-window pixel
        send_cmd(8'h11);
        n0 = n_pix;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        idle(3);
        check("ignore_no_pixel", 64'(n_pix), 64'(n0));
        check("ignore_cmd_held", 64'(cmd), 64'h11);
        send_cmd(8'h2C);
        send_pix(16'h1234, 9'd0, 9'd0);
        drain("unknown");

        // Window write with wrap in both axes
        n0 = n_cmd;
        send_cmd(8'h2A);
        send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
        send_cmd(8'h2B);
        send_byte(8'h00, 1'b1); send_byte(8'h14, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h14, 1'b1);
        send_cmd(8'h2C);
        pix_cyc.delete();
        send_pix(16'hF800, 9'd10, 9'd20);
        send_pix(16'h07E0, 9'd11, 9'd20);
        send_pix(16'h001F, 9'd10, 9'd20);
        send_pix(16'hFFFF, 9'd11, 9'd20);
        drain("window");
        check("window_cmd_count", 64'(n_cmd - n0), 64'd3);
        check("window_pix_count", 64'(pix_cyc.size()), 64'd4);
        for (int i = 1; i < 4; i++)
            if (i < pix_cyc.size())
                check("pix_spacing", 64'(pix_cyc[i] - pix_cyc[i-1]), 64'd16);
        check("window_err_clear", 64'(err), 64'd0);

        // CS abort mid-byte
        n0 = n_cmd;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            spi_bus.cs   = 1'b0;
            spi_bus.mosi = 1'(i % 2);
            spi_bus.dc   = 1'b1;
        end
        @(negedge clk);
        spi_bus.cs = 1'b1;
        send_cmd(8'h2C);
        idle(3);
        check("abort_cmd_count", 64'(n_cmd - n0), 64'd1);
        check("abort_cmd_value", 64'(cmd), 64'h2C);
        drain("abort");

        // CASET out of range: flag rises with the 4th byte's strobe slot and sticks
        send_cmd(8'h2A);
        send_byte(8'h00, 1'b1); send_byte(8'hF0, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'hF5, 1'b1);
        check("caset_err_before_edge", 64'(err), 64'd0);
        @(negedge clk);
        spi_bus.cs = 1'b1;
        check("caset_err_set", 64'(err), 64'd1);
        send_cmd(8'h2B);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
        send_cmd(8'h2C);
        send_pix(16'h0001, 9'd240, 9'd0);
        drain("caset_err");
        check("caset_err_sticky", 64'(err), 64'd1);

        // Reset, then PASET with start > end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("err_cleared_by_reset", 64'(err), 64'd0);
        send_cmd(8'h2B);
        send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        idle(2);
        check("paset_err_set", 64'(err), 64'd1);
        send_cmd(8'h2C);
        send_pix(16'h1234, 9'd0, 9'd32);
        drain("paset_err");

        // Reset mid-RAMWR drops the pending high byte
        send_cmd(8'h2C);
        send_byte(8'hAB, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_ramwr_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = n_cmd + n_pix;
        send_byte(8'hCD, 1'b1);
        idle(3);
        check("lost_high_byte_no_pixel", 64'(n_cmd + n_pix), 64'(n0));
        drain("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_display_receiver.md
# spi_display_receiver

Receive-side model of the display-controller SPI link driven by the team's drawing engines (line, horizontal and polygon sequencers). It deserialises the MOSI/DC/CS stream, decodes the window and memory-write commands (0x2A, 0x2B, 0x2C), and emits one coordinate-tagged pixel strobe per received RGB565 word. It feeds frame-capture logic in simulation and on-FPGA self-check, and serves as the reference checker for every `SPI_*` drawing block.

## Interface
- `WIDTH`, default 240: panel columns; column addresses ≥ WIDTH are errors.
- `HEIGHT`, default 320: panel rows; page addresses ≥ HEIGHT are errors.
- `i_clk`  in  1  system clock; it is also the SPI bit clock. One bit per cycle while CS is low.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_mosi`  in  1  serial data, MSB first.
- `i_dc`  in  1  0 = command byte, 1 = data byte; sampled with the byte's 8th bit.
- `i_cs`  in  1  chip select, active-low.
- `o_cmd_valid`  out  1  one-cycle strobe per command byte.
- `o_cmd`  out  8  last command byte; held between strobes.
- `o_pix_valid`  out  1  one-cycle strobe per pixel.
- `o_pix_x`  out  9  pixel column.
- `o_pix_y`  out  9  pixel row.
- `o_pix_color`  out  16  RGB565 value {high byte, low byte}.
- `o_err`  out  1  sticky window-error flag.

## Operation
- **Byte assembly**
  - While `i_cs` = 0, each rising edge shifts `i_mosi` into an 8-bit register and increments a 3-bit bit counter.
  - When the counter wraps (8th bit), the byte is complete. Its type is `i_dc` sampled on that same edge.
  - `i_cs` = 1 clears the bit counter and discards any partial byte.
  - Command and decode context survive CS toggling.
- **Decode FSM states:** CMD, CASET, PASET, RAMWR, IGNORE.
- **Command byte (any state):**
  - Pulse `o_cmd_valid` and load `o_cmd`.
  - Clear the parameter index and the pixel-half flag.
  - Next state: 0x2A → CASET; 0x2B → PASET; 0x2C → RAMWR with cursor (x, y) = (XS, YS); any other value → IGNORE.
- **CASET / PASET data:**
  - Four bytes, in order: start high, start low, end high, end low. Each 16-bit value is truncated to 9 bits.
  - On the 4th byte, commit the start/end pair and return to CMD.
  - Set `o_err` if start > end, or end ≥ WIDTH (CASET) / ≥ HEIGHT (PASET). The window is committed regardless.
  - Data beyond the 4th byte is ignored.
- **RAMWR data:**
  - Bytes alternate high, low. On the low byte, emit the pixel at the cursor, then advance the cursor.
  - Column advance: x = XE → x = XS and the row advances; otherwise x + 1.
  - Row advance: y = YE → y = YS (frame wrap); otherwise y + 1.
  - The cursor is 9-bit unsigned.
- **Other cases:** data bytes in CMD or IGNORE are dropped silently.
- **Reset values:**
  - All outputs 0; FSM in CMD; bit counter 0.
  - Window XS = 0, XE = WIDTH−1, YS = 0, YE = HEIGHT−1.
  - Cursor (0, 0); `o_err` = 0.

## Timing
- Edge E samples the 8th bit of a byte. The registered strobe is high during the cycle after E, for exactly one cycle.
  - Pixel coordinates and colour are valid in that same cycle and hold until the next strobe.
  - Command and pixel strobes never coincide.
- Back-to-back bytes: a new byte may begin on the edge after E. The decoder accepts one byte every 8 cycles indefinitely, with no stalls.
- Pixel throughput: at most one pixel per 16 cycles.
- `o_err` rises in the same cycle as the strobe would for the offending 4th parameter byte. It clears only on reset.
- `i_rst_n` low mid-byte or mid-pixel: all state returns to reset values immediately. A pending high byte is lost.
- CS high for one cycle between bytes costs no data. CS high mid-byte loses that byte only.

## Test plan
- **Reset:** assert `i_rst_n` = 0 with random MOSI/DC/CS.
  - All outputs 0.
  - After release, a data byte with CS low produces no strobe.
- **Window write:** send cmd 2A, data 00 0A 00 0B; cmd 2B, data 00 14 00 14; cmd 2C; then pixels F800, 07E0, 001F, FFFF.
  - Three `o_cmd_valid` pulses (2A, 2B, 2C).
  - Four `o_pix_valid` pulses, each 16 cycles apart: (10,20)=F800, (11,20)=07E0, (10,20)=001F, (11,20)=FFFF.
  - `o_err` stays 0.
- **CS abort:** CS low for 5 bits, CS high for 1 cycle, then full byte 0x2C with DC = 0.
  - Exactly one `o_cmd_valid` pulse, with `o_cmd` = 2C.
- **Window errors:**
  - CASET 00 F0 00 F5 → `o_err` = 1, and it stays 1 through later valid traffic.
  - Separately, PASET 00 20 00 10 → `o_err` = 1.
- **Unknown command:** cmd 0x11, data AA 55.
  - `o_cmd_valid` with `o_cmd` = 11; no pixel strobe.
  - Then cmd 2C, data 12 34 → pixel (0,0) = 1234.
- **Reset mid-RAMWR:** cmd 2C, high byte AB, then pulse `i_rst_n` low.
  - Outputs clear immediately.
  - After release, byte CD with DC = 1 produces no pixel.
